// File: rtl/quad_pixel_fetch.sv
// Fetches the 2x2 source-pixel neighbourhood for one bilinear sample.
// A request is accepted, edge-clamped, and four reads go out back to back.
// The quad and the pass-through weights are then presented over valid/ready.
module quad_pixel_fetch #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAC_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [15:0]          cfg_width_i,
  input  logic [15:0]          cfg_height_i,
  input  logic [ADDR_BITS-1:0] cfg_base_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [15:0]          req_x_i,
  input  logic [15:0]          req_y_i,
  input  logic [FRAC_W-1:0]    req_fx_i,
  input  logic [FRAC_W-1:0]    req_fy_i,
  output logic                 mem_rd_en_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_W-1:0]    out_p00_o,
  output logic [DATA_W-1:0]    out_p01_o,
  output logic [DATA_W-1:0]    out_p10_o,
  output logic [DATA_W-1:0]    out_p11_o,
  output logic [FRAC_W-1:0]    out_fx_o,
  output logic [FRAC_W-1:0]    out_fy_o,
  output logic                 out_err_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  state_e               state_q;
  logic [1:0]           idx_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [ADDR_BITS-1:0] addr1_q, addr2_q, addr3_q;
  logic [DATA_W-1:0]    p00_q, p01_q, p10_q, p11_q;
  logic [FRAC_W-1:0]    fx_q, fy_q;
  logic                 err_q;

  logic                 zero_size;
  logic [15:0]          w_max, h_max, x0, x1, y0, y1;
  logic [ADDR_BITS-1:0] row0, row1, acc_a0, acc_a1, acc_a2, acc_a3;

  // Clamp the request to the image and form all four read addresses at accept.
  // With a zero dimension w_max/h_max wrap, but those addresses are never issued.
  always_comb begin
    zero_size = (cfg_width_i == 16'd0) || (cfg_height_i == 16'd0);
    w_max     = cfg_width_i - 16'd1;
    h_max     = cfg_height_i - 16'd1;
    x0        = (req_x_i > w_max) ? w_max : req_x_i;
    y0        = (req_y_i > h_max) ? h_max : req_y_i;
    x1        = (x0 == w_max) ? x0 : x0 + 16'd1;
    y1        = (y0 == h_max) ? y0 : y0 + 16'd1;
    // Products are taken at address width so the result wraps modulo 2^ADDR_BITS.
    row0      = cfg_base_i + ADDR_BITS'(y0) * ADDR_BITS'(cfg_width_i);
    row1      = cfg_base_i + ADDR_BITS'(y1) * ADDR_BITS'(cfg_width_i);
    acc_a0    = row0 + ADDR_BITS'(x0);
    acc_a1    = row0 + ADDR_BITS'(x1);
    acc_a2    = row1 + ADDR_BITS'(x0);
    acc_a3    = row1 + ADDR_BITS'(x1);
  end

  // Control FSM: issue four reads, capture data one cycle behind, hold quad until taken.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      mem_addr_q <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addr3_q    <= '0;
      p00_q      <= '0;
      p01_q      <= '0;
      p10_q      <= '0;
      p11_q      <= '0;
      fx_q       <= '0;
      fy_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            fx_q  <= req_fx_i;
            fy_q  <= req_fy_i;
            err_q <= zero_size;
            idx_q <= 2'd0;
            if (zero_size) begin
              p00_q   <= '0;
              p01_q   <= '0;
              p10_q   <= '0;
              p11_q   <= '0;
              state_q <= StOut;
            end else begin
              mem_addr_q <= acc_a0;
              addr1_q    <= acc_a1;
              addr2_q    <= acc_a2;
              addr3_q    <= acc_a3;
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
          idx_q <= idx_q + 2'd1;
          // Data for read k arrives while read k+1 is on the bus.
          unique case (idx_q)
            2'd0: mem_addr_q <= addr1_q;
            2'd1: begin
              mem_addr_q <= addr2_q;
              p00_q      <= mem_rdata_i;
            end
            2'd2: begin
              mem_addr_q <= addr3_q;
              p01_q      <= mem_rdata_i;
            end
            2'd3: begin
              p10_q   <= mem_rdata_i;
              state_q <= StDrain;
            end
          endcase
        end
        StDrain: begin
          p11_q   <= mem_rdata_i;
          state_q <= StOut;
        end
        StOut: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign mem_rd_en_o = (state_q == StIssue);
  assign out_valid_o = (state_q == StOut);
  assign mem_addr_o  = mem_addr_q;
  assign out_p00_o   = p00_q;
  assign out_p01_o   = p01_q;
  assign out_p10_o   = p10_q;
  assign out_p11_o   = p11_q;
  assign out_fx_o    = fx_q;
  assign out_fy_o    = fy_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_quad_pixel_fetch.sv
// Self-checking bench for quad_pixel_fetch: directed cases with literal
// expectations, then randomized traffic checked cycle by cycle against a model.
module tb_quad_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfg_width, cfg_height, cfg_base;
  logic        req_valid, req_ready;
  logic [15:0] req_x, req_y;
  logic [7:0]  req_fx, req_fy;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        out_valid, out_ready;
  logic [7:0]  out_p00, out_p01, out_p10, out_p11, out_fx, out_fy;
  logic        out_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  quad_pixel_fetch dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cfg_width_i (cfg_width),
    .cfg_height_i(cfg_height),
    .cfg_base_i  (cfg_base),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_x_i     (req_x),
    .req_y_i     (req_y),
    .req_fx_i    (req_fx),
    .req_fy_i    (req_fy),
    .mem_rd_en_o (mem_rd_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_p00_o   (out_p00),
    .out_p01_o   (out_p01),
    .out_p10_o   (out_p10),
    .out_p11_o   (out_p11),
    .out_fx_o    (out_fx),
    .out_fy_o    (out_fy),
    .out_err_o   (out_err),
    .busy_o      (busy)
  );

  function automatic logic [7:0] sram(input logic [15:0] a);
    return a[7:0];
  endfunction

  // SRAM with one cycle of read latency
  always @(posedge clk) mem_rdata <= sram(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts clock edges since the accept edge of the current request.
  bit          m_started = 1'b0;
  bit          m_act, m_zero, m_err;
  int          m_n;
  logic [15:0] m_a[4];
  logic [7:0]  m_q[4];
  logic [7:0]  m_fx, m_fy;
  logic [15:0] m_last;

  always @(posedge clk) begin
    int unsigned w, h, x0, x1, y0, y1;
    if (reset) begin
      m_started = 1'b1;
      m_act     = 1'b0;
      m_err     = 1'b0;
      m_last    = 16'h0;
    end else begin
      if (m_act && (m_zero || m_n >= 5) && out_ready) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_n++;
      end else if (req_valid) begin
        w      = cfg_width;
        h      = cfg_height;
        m_zero = (w == 0) || (h == 0);
        m_err  = m_zero;
        m_fx   = req_fx;
        m_fy   = req_fy;
        if (!m_zero) begin
          x0     = (req_x < w) ? req_x : w - 1;
          y0     = (req_y < h) ? req_y : h - 1;
          x1     = (x0 + 1 < w) ? x0 + 1 : w - 1;
          y1     = (y0 + 1 < h) ? y0 + 1 : h - 1;
          m_a[0] = 16'(cfg_base + y0 * w + x0);
          m_a[1] = 16'(cfg_base + y0 * w + x1);
          m_a[2] = 16'(cfg_base + y1 * w + x0);
          m_a[3] = 16'(cfg_base + y1 * w + x1);
        end
        for (int k = 0; k < 4; k++) m_q[k] = m_zero ? 8'h00 : sram(m_a[k]);
        m_act = 1'b1;
        m_n   = 0;
      end
      if (m_act && !m_zero && m_n <= 3) m_last = m_a[m_n];
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    bit e_valid, e_rd;
    if (m_started) begin
      e_valid = m_act && (m_zero || m_n >= 5);
      e_rd    = m_act && !m_zero && m_n <= 3;
      check("req_ready", 64'(req_ready), 64'(!m_act));
      check("busy", 64'(busy), 64'(m_act));
      check("mem_rd_en", 64'(mem_rd_en), 64'(e_rd));
      check("mem_addr", 64'(mem_addr), 64'(m_last));
      check("out_valid", 64'(out_valid), 64'(e_valid));
      check("out_err", 64'(out_err), 64'(m_err));
      if (e_valid) begin
        check("quad", {out_p00, out_p01, out_p10, out_p11}, {m_q[0], m_q[1], m_q[2], m_q[3]});
        check("fx_fy", {out_fx, out_fy}, {m_fx, m_fy});
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Issue one request, record read addresses, latency (edges from accept to
  // first out_valid cycle) and the presented quad; hold out_ready low `hold` cycles.
  task automatic run_req(input logic [15:0] x, input logic [15:0] y, input logic [7:0] fx,
                         input logic [7:0] fy, input int hold, output int lat, output int na,
                         output logic [15:0] ad[4], output logic [31:0] q,
                         output logic [15:0] fxy, output logic er);
    int k;
    int held;
    req_x = x; req_y = y; req_fx = fx; req_fy = fy;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; na = 0; held = 0; q = '0; fxy = '0; er = 1'b0;
    for (int i = 0; i < 4; i++) ad[i] = 16'h0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (na < 4) ad[na] = mem_addr;
        na++;
      end
      if (out_valid) begin
        if (lat < 0) begin
          lat = n - 1;
          q   = {out_p00, out_p01, out_p10, out_p11};
          fxy = {out_fx, out_fy};
          er  = out_err;
        end else begin
          check("quad_hold", {out_p00, out_p01, out_p10, out_p11}, q);
        end
        check("req_ready_in_out", 64'(req_ready), 64'd0);
        if (held >= hold) begin
          out_ready = 1'b1;
          @(posedge clk); #1;
          out_ready = 1'b0;
          break;
        end
        held++;
      end
    end
    if (lat < 0) check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic check_addrs(input string name, input int na, input logic [15:0] ad[4],
                             input logic [63:0] exp);
    check({name, "_nreads"}, 64'(na), 64'd4);
    check({name, "_addrs"}, {ad[0], ad[1], ad[2], ad[3]}, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, na, k;
    logic [15:0] ad[4];
    logic [31:0] q;
    logic [15:0] fxy;
    logic        er;

    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    req_x = '0; req_y = '0; req_fx = '0; req_fy = '0;
    cfg_width = 16'd4; cfg_height = 16'd3; cfg_base = 16'h0100;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outs", {req_ready, busy, mem_rd_en, out_valid, out_err, mem_addr},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    check("reset_quad", {out_p00, out_p01, out_p10, out_p11, out_fx, out_fy}, 48'h0);

    // 1: interior quad
    run_req(16'd1, 16'd1, 8'h40, 8'h80, 0, lat, na, ad, q, fxy, er);
    check_addrs("t1", na, ad, 64'h0105_0106_0109_010A);
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_quad", 64'(q), 64'h0506090A);
    check("t1_fxfy", 64'(fxy), 64'h4080);
    @(negedge clk);
    check("t1_idle_after", 64'(req_ready), 64'd1);

    // 2: bottom-right corner clamp
    run_req(16'd3, 16'd2, 8'h11, 8'h22, 0, lat, na, ad, q, fxy, er);
    check_addrs("t2", na, ad, 64'h010B_010B_010B_010B);
    check("t2_quad", 64'(q), 64'h0B0B0B0B);

    // 3: column beyond the image
    run_req(16'd9, 16'd0, 8'h33, 8'h44, 0, lat, na, ad, q, fxy, er);
    check_addrs("t3", na, ad, 64'h0103_0103_0107_0107);
    check("t3_quad", 64'(q), 64'h03030707);

    // 4: backpressure for three cycles
    run_req(16'd2, 16'd0, 8'h55, 8'h66, 3, lat, na, ad, q, fxy, er);
    check("t4_quad", 64'(q), 64'h02030607);
    @(negedge clk);
    check("t4_idle_after", 64'({req_ready, busy}), 64'b10);

    // 5: reset while the third read is on the bus
    req_x = 16'd1; req_y = 16'd1; req_fx = 8'h40; req_fy = 8'h80;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mem_rd_en && mem_addr == 16'h0109) && k < 10);
    check("t5_reached_idx2", 64'(mem_addr), 64'h0109);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_after_reset", 64'({mem_rd_en, out_valid, req_ready}), 64'b001);
    run_req(16'd1, 16'd1, 8'h40, 8'h80, 0, lat, na, ad, q, fxy, er);
    check_addrs("t5b", na, ad, 64'h0105_0106_0109_010A);
    check("t5b_quad", 64'(q), 64'h0506090A);

    // 6: zero width, then a valid request clears the error
    cfg_width = 16'd0;
    run_req(16'd1, 16'd1, 8'h12, 8'h34, 0, lat, na, ad, q, fxy, er);
    check("t6_nreads", 64'(na), 64'd0);
    check("t6_latency", 64'(lat), 64'd0);
    check("t6_quad_err", 64'({q, er}), 64'({32'h0, 1'b1}));
    cfg_width = 16'd4;
    run_req(16'd0, 16'd0, 8'h01, 8'h02, 0, lat, na, ad, q, fxy, er);
    check("t6b_err", 64'(er), 64'd0);
    check("t6b_quad", 64'(q), 64'h00010405);

    // randomized traffic; configuration also changes while busy
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 299) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 9) < 6;
      case ($urandom_range(0, 9))
        0:       cfg_width = 16'd0;
        1:       cfg_width = 16'($urandom);
        default: cfg_width = 16'($urandom_range(1, 8));
      endcase
      case ($urandom_range(0, 9))
        0:       cfg_height = 16'd0;
        1:       cfg_height = 16'($urandom);
        default: cfg_height = 16'($urandom_range(1, 8));
      endcase
      cfg_base = 16'($urandom);
      req_x    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
      req_y    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
      req_fx   = 8'($urandom);
      req_fy   = 8'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
